// File: rtl/tf_fetch_scheduler_pkg.sv
// tf_fetch_scheduler_pkg: shared types, defaults and stage base helper for the twiddle fetch scheduler
package tf_fetch_scheduler_pkg;
  localparam int NSTAGE_D = 3;
  localparam int ROM_LAT_D = 1;
  localparam int BUF_LAT_D = 5;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  typedef struct packed {
    logic valid;
    logic [1:0] stage;
    logic last;
  } tag_t;
  // (16^s - 1) / 15, i.e. the number of ROM words used by all earlier stages
  function automatic int stage_base(input int s);
    int b;
    b = 0;
    for (int i = 0; i < 4; i++) b = (i < s) ? b * 16 + 1 : b;
    return b;
  endfunction
endpackage

// File: rtl/tf_fetch_scheduler_if.sv
// tf_fetch_scheduler_if: control and ROM/delay-buffer handshake bundle of the twiddle fetch scheduler
interface tf_fetch_scheduler_if #(parameter int ADDR_W = 9);
  logic start, bu_ready, busy, done, rom_en, tf_valid, tf_last;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0] tf_stage;
  modport master(output start, bu_ready, input busy, done, rom_en, rom_addr, tf_valid, tf_stage, tf_last);
  modport slave(input start, bu_ready, output busy, done, rom_en, rom_addr, tf_valid, tf_stage, tf_last);
endinterface

// File: rtl/tf_fetch_scheduler_valid_tracker.sv
// tf_fetch_scheduler_valid_tracker: fixed-latency tag shift register mirroring the ROM plus delay buffer
module tf_fetch_scheduler_valid_tracker
  import tf_fetch_scheduler_pkg::*;
#(
  parameter int DEPTH = ROM_LAT_D + BUF_LAT_D
) (
  input  logic clk,
  input  logic rst,
  input  tag_t din,
  output tag_t dout,
  output logic pending
);
  tag_t [DEPTH-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= {sr[DEPTH-2:0], din};
  // pending covers entries still to reach the tail, not the one presented now
  always_comb begin
    pending = din.valid;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | sr[i].valid;
  end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/tf_fetch_scheduler.sv
// tf_fetch_scheduler: walks NTT stages/groups, issues shared twiddle ROM addresses and tracks them to the butterfly unit
module tf_fetch_scheduler
  import tf_fetch_scheduler_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_D,
  parameter int ROM_LAT = ROM_LAT_D,
  parameter int BUF_LAT = BUF_LAT_D,
  parameter int ADDR_W = 9
) (
  input logic clk,
  input logic rst,
  tf_fetch_scheduler_if.slave bus
);
  localparam int GW = 4 * (NSTAGE - 1);
  localparam logic [GW-1:0] G_MAX = '1;
  state_t state, state_n;
  logic [1:0] s;
  logic [GW-1:0] g;
  logic issue, last_grp, pending, busy, done;
  logic [ADDR_W-1:0] addr, rom_addr;
  tag_t tag, tail;
  // issue is decided at the edge that launches it, so the first fetch can leave IDLE with start
  always_comb begin
    last_grp = s == 2'(NSTAGE - 1) && g == G_MAX;
    issue = bus.bu_ready && (state == FETCH || (state == IDLE && bus.start));
    addr = ADDR_W'(stage_base(int'(s))) + ADDR_W'(g >> (4 * (NSTAGE - 1 - int'(s))));
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? FETCH : IDLE;
      FETCH: state_n = (issue && last_grp) ? DRAIN : FETCH;
      DRAIN: state_n = pending ? DRAIN : DONE;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      s <= '0;
      g <= '0;
      tag <= '0;
      rom_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tag <= '{valid: issue, stage: s, last: issue && last_grp};
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      if (issue) rom_addr <= addr;
      if (issue) begin
        g <= g + 1'b1;
        if (g == G_MAX) s <= s + 1'b1;
      end else if (state != FETCH) begin
        s <= '0;
        g <= '0;
      end
    end
  tf_fetch_scheduler_valid_tracker #(.DEPTH(ROM_LAT + BUF_LAT)) u_tracker (
    .clk(clk),
    .rst(rst),
    .din(tag),
    .dout(tail),
    .pending(pending)
  );
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.rom_en = tag.valid;
  assign bus.rom_addr = rom_addr;
  assign bus.tf_valid = tail.valid;
  assign bus.tf_stage = tail.stage;
  assign bus.tf_last = tail.last;
endmodule

// File: tb/tb_tf_fetch_scheduler.sv
// tb_tf_fetch_scheduler: scoreboard bench for the twiddle fetch scheduler with directed transform scenarios
module tb_tf_fetch_scheduler;
  import tf_fetch_scheduler_pkg::*;
  typedef struct {int c; int a;} rom_e;
  typedef struct {int c; int st; int last;} tf_e;
  logic clk, rst;
  int cyc = 0;
  int cmp_n = 0;
  int err_n = 0;
  rom_e q_rom[$];
  tf_e q_tf[$];
  int q_done[$];
  tf_fetch_scheduler_if #(.ADDR_W(9)) bus();
  tf_fetch_scheduler #(.NSTAGE(3), .ROM_LAT(1), .BUF_LAT(5), .ADDR_W(9)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // expected issue/delivery schedule of one transform started in cycle k, optional stall after 9 issues
  task automatic push_run(input int k, input int stall);
    int a, c;
    for (int i = 0; i < 768; i++) begin
      a = (i < 256) ? 0 : (i < 512) ? 1 + (i - 256) / 16 : 17 + (i - 512);
      c = k + 1 + i + ((i >= 9) ? stall : 0);
      q_rom.push_back('{c: c, a: a});
      q_tf.push_back('{c: c + 6, st: i / 256, last: (i == 767) ? 1 : 0});
    end
    q_done.push_back(k + 775 + stall);
  endtask
  always @(negedge clk) if (!rst) begin
    rom_e re;
    tf_e te;
    if (bus.rom_en) begin
      if (q_rom.size() == 0) chk("rom_en_unexpected", int'(bus.rom_en), 0);
      else begin
        re = q_rom.pop_front();
        chk("rom_cycle", cyc, re.c);
        chk("rom_addr", int'(bus.rom_addr), re.a);
      end
    end
    if (bus.tf_valid) begin
      if (q_tf.size() == 0) chk("tf_valid_unexpected", int'(bus.tf_valid), 0);
      else begin
        te = q_tf.pop_front();
        chk("tf_cycle", cyc, te.c);
        chk("tf_stage", int'(bus.tf_stage), te.st);
        chk("tf_last", int'(bus.tf_last), te.last);
      end
    end else chk("tf_last_stray", int'(bus.tf_last), 0);
    if (bus.done) begin
      if (q_done.size() == 0) chk("done_unexpected", int'(bus.done), 0);
      else chk("done_cycle", cyc, q_done.pop_front());
    end
  end
  task automatic transform(input int stall, input bit restart, output int d);
    int k;
    k = cyc;
    bus.start = 1'b1;
    push_run(k, stall);
    d = -1;
    for (int n = 0; n < 1000 && d < 0; n++) begin
      @(negedge clk);
      bus.start = restart && cyc == k + 100;
      bus.bu_ready = !(stall > 0 && cyc >= k + 9 && cyc < k + 9 + stall);
      if (bus.busy !== 1'b1 && bus.done !== 1'b1) chk("busy_during_run", int'(bus.busy), 1);
      if (bus.done) d = cyc;
    end
    if (d < 0) chk("done_seen", int'(bus.done), 1);
    bus.start = 1'b0;
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_rom_en"}, int'(bus.rom_en), 0);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_tf_valid"}, int'(bus.tf_valid), 0);
    chk({tag, "_tf_stage"}, int'(bus.tf_stage), 0);
    chk({tag, "_tf_last"}, int'(bus.tf_last), 0);
    chk({tag, "_fsm"}, int'(dut.state), int'(IDLE));
  endtask
  initial begin
    int d;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bu_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    transform(0, 1'b0, d);
    repeat (3) @(negedge clk);
    transform(10, 1'b0, d);
    repeat (3) @(negedge clk);
    transform(0, 1'b1, d);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    push_run(cyc, 0);
    repeat (400) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    q_rom.delete();
    q_tf.delete();
    q_done.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    transform(0, 1'b0, d);
    bus.start = 1'b1;
    @(negedge clk);
    transform(0, 1'b0, d);
    repeat (20) @(negedge clk);
    chk("rom_left", q_rom.size(), 0);
    chk("tf_left", q_tf.size(), 0);
    chk("done_left", q_done.size(), 0);
    chk("final_busy", int'(bus.busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
